// File: rtl/trace_pkg.sv
// Shared definitions for the retire-trace buffer: FSM encoding and the
// record layout {pc, inst, wen, wb_addr, wb_data}, MSB first.
package trace_pkg;

  localparam int WB_ADDR_W = 5;
  localparam int INST_W    = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Bit offsets of each field inside a record, for a given XLEN.
  function automatic int off_wb_data(input int xlen);
    return 0;
  endfunction

  function automatic int off_wb_addr(input int xlen);
    return xlen;
  endfunction

  function automatic int off_wen(input int xlen);
    return xlen + WB_ADDR_W;
  endfunction

  function automatic int off_inst(input int xlen);
    return xlen + WB_ADDR_W + 1;
  endfunction

  function automatic int off_pc(input int xlen);
    return xlen + WB_ADDR_W + 1 + INST_W;
  endfunction

  function automatic int rec_w(input int xlen);
    return 2 * xlen + INST_W + WB_ADDR_W + 1;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace storage: DEPTH x W register array, one synchronous write port and
// one combinational read port. Contents are intentionally not reset.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [W-1:0]             i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [W-1:0]             o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/trace_buffer.sv
// Retire-trace logic analyser: circular capture until exit or pc-match
// trigger, POST_TRIG further entries, then oldest-first drain over valid/ready.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for arm; buffer holds the last captured window
//   ARMED    | capturing into the ring, watching for a trigger
//   POST     | capturing POST_TRIG more valid records after the trigger
//   DRAIN    | presenting entries oldest-first on rd_valid/rd_ready
module trace_buffer
  import trace_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid,
  input  logic [XLEN-1:0]            pc,
  input  logic [INST_W-1:0]          inst,
  input  logic                       wen,
  input  logic [WB_ADDR_W-1:0]       wb_addr,
  input  logic [XLEN-1:0]            wb_data,
  input  logic                       exit,
  input  logic                       arm,
  input  logic                       trig_pc_en,
  input  logic [XLEN-1:0]            trig_pc,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [2*XLEN+INST_W+WB_ADDR_W:0] rd_data,
  output logic                       busy,
  output logic                       triggered,
  output logic [$clog2(DEPTH):0]     entries
);

  localparam int REC_W = rec_w(XLEN);
  localparam int PW    = $clog2(DEPTH);
  localparam int EW    = PW + 1;

  state_t          r_state, w_next;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_post_cnt;
  logic [EW-1:0]   r_entries;
  logic            r_busy;
  logic            r_triggered;

  logic            w_capture;
  logic            w_trig;
  logic            w_post_done;
  logic            w_rd_fire;
  logic [PW-1:0]   w_rd_ptr;
  logic [REC_W-1:0] w_rec;
  logic [REC_W-1:0] w_rd_rec;

  assign w_capture   = valid && ((r_state == ST_ARMED) || (r_state == ST_POST));
  assign w_trig      = (r_state == ST_ARMED) &&
                       (exit || (valid && trig_pc_en && (pc == trig_pc)));
  assign w_post_done = (r_state == ST_POST) && valid && (r_post_cnt == PW'(1));

  // wr_ptr is frozen in DRAIN and entries drops by one per handshake, so this
  // difference walks forward from the oldest entry without its own register.
  assign w_rd_ptr  = r_wr_ptr - r_entries[PW-1:0];
  assign rd_valid  = (r_state == ST_DRAIN) && (r_entries != '0);
  assign w_rd_fire = rd_valid && rd_ready;

  always_comb begin
    w_rec = '0;
    w_rec[off_wb_data(XLEN) +: XLEN]      = wb_data;
    w_rec[off_wb_addr(XLEN) +: WB_ADDR_W] = wb_addr;
    w_rec[off_wen(XLEN)]                  = wen;
    w_rec[off_inst(XLEN) +: INST_W]       = inst;
    w_rec[off_pc(XLEN) +: XLEN]           = pc;
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_ram (
    .i_clk   (clk),
    .i_we    (w_capture),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_rec),
    .i_raddr (w_rd_ptr),
    .o_rdata (w_rd_rec)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (arm) w_next = ST_ARMED;
      ST_ARMED: if (w_trig) w_next = (POST_TRIG == 0) ? ST_DRAIN : ST_POST;
      ST_POST:  if (w_post_done) w_next = ST_DRAIN;
      ST_DRAIN: begin
        if ((r_entries == '0) || (w_rd_fire && (r_entries == EW'(1))))
          w_next = ST_IDLE;
      end
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_post_cnt  <= '0;
      r_entries   <= '0;
      r_busy      <= 1'b0;
      r_triggered <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != ST_IDLE);
      if ((r_state == ST_IDLE) && arm) begin
        r_wr_ptr    <= '0;
        r_entries   <= '0;
        r_post_cnt  <= '0;
        r_triggered <= 1'b0;
      end else begin
        if (w_capture) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          if (r_entries != EW'(DEPTH)) r_entries <= r_entries + 1'b1;
        end else if (w_rd_fire) begin
          r_entries <= r_entries - 1'b1;
        end
        // Post-trigger down-counter: loaded at the trigger, terminal count 1.
        if (w_trig) begin
          r_triggered <= 1'b1;
          r_post_cnt  <= PW'(POST_TRIG);
        end else if ((r_state == ST_POST) && valid) begin
          r_post_cnt <= r_post_cnt - 1'b1;
        end
      end
    end
  end

  assign rd_data   = rd_valid ? w_rd_rec : '0;
  assign busy      = r_busy;
  assign triggered = r_triggered;
  assign entries   = r_entries;

endmodule

// File: tb/tb_trace_buffer.sv
// Directed bench for trace_buffer: instance A (DEPTH=8, POST_TRIG=4) and
// instance B (DEPTH=8, POST_TRIG=0) sharing the retire bus.
module tb_trace_buffer;

  localparam int XLEN  = 32;
  localparam int REC_W = 2 * XLEN + 38;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              valid;
  logic [XLEN-1:0]   pc;
  logic [31:0]       inst;
  logic              wen;
  logic [4:0]        wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic              exit_i;
  logic              arm_a, arm_b;
  logic              trig_pc_en;
  logic [XLEN-1:0]   trig_pc;
  logic              rd_ready;

  logic              rdv_a, rdv_b;
  logic [REC_W-1:0]  rdd_a, rdd_b;
  logic              busy_a, busy_b;
  logic              trg_a, trg_b;
  logic [3:0]        ent_a, ent_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  trace_buffer #(.XLEN(XLEN), .DEPTH(8), .POST_TRIG(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .valid(valid), .pc(pc), .inst(inst), .wen(wen),
    .wb_addr(wb_addr), .wb_data(wb_data), .exit(exit_i), .arm(arm_a),
    .trig_pc_en(trig_pc_en), .trig_pc(trig_pc), .rd_valid(rdv_a),
    .rd_ready(rd_ready), .rd_data(rdd_a), .busy(busy_a), .triggered(trg_a),
    .entries(ent_a)
  );

  trace_buffer #(.XLEN(XLEN), .DEPTH(8), .POST_TRIG(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .valid(valid), .pc(pc), .inst(inst), .wen(wen),
    .wb_addr(wb_addr), .wb_data(wb_data), .exit(exit_i), .arm(arm_b),
    .trig_pc_en(trig_pc_en), .trig_pc(trig_pc), .rd_valid(rdv_b),
    .rd_ready(rd_ready), .rd_data(rdd_b), .busy(busy_b), .triggered(trg_b),
    .entries(ent_b)
  );

  function automatic logic [31:0] f_inst(input logic [31:0] p);
    return p ^ 32'h00A0_0093;
  endfunction
  function automatic logic [31:0] f_data(input logic [31:0] p);
    return ~p ^ 32'h1234_5678;
  endfunction
  function automatic logic [REC_W-1:0] exp_rec(input logic [31:0] p);
    return {p, f_inst(p), p[2], p[6:2], f_data(p)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [31:0] p);
    valid   = 1'b1;
    pc      = p;
    inst    = f_inst(p);
    wen     = p[2];
    wb_addr = p[6:2];
    wb_data = f_data(p);
    tick();
    valid   = 1'b0;
  endtask

  task automatic pulse_arm(input bit sel);
    if (sel) arm_b = 1'b1; else arm_a = 1'b1;
    tick();
    arm_a = 1'b0;
    arm_b = 1'b0;
  endtask

  // Drains n records expected at pc base, base+4, ...; optional 1,0,0,1 stall.
  task automatic drain(input bit sel, input logic [31:0] base, input int n, input bit stall);
    int idx = 0;
    int cyc = 0;
    logic [3:0] pat = 4'b1001;
    while (idx < n && cyc < 40) begin
      chk("rd_valid", sel ? rdv_b : rdv_a, 1'b1);
      chk("rd_data",  sel ? rdd_b : rdd_a, exp_rec(base + 32'(4 * idx)));
      rd_ready = (stall && cyc < 4) ? pat[cyc[1:0]] : 1'b1;
      tick();
      if (rd_ready) idx++;
      cyc++;
    end
    rd_ready = 1'b0;
    chk("drain_count", idx, n);
    chk("idle_busy",   sel ? busy_b : busy_a, 1'b0);
    chk("idle_rdv",    sel ? rdv_b : rdv_a, 1'b0);
    chk("idle_entries", sel ? ent_b : ent_a, 4'd0);
  endtask

  initial begin
    // Reset with random inputs
    rst_n      = 1'b0;
    valid      = 1'($urandom_range(0, 1));
    pc         = $urandom;
    inst       = $urandom;
    wen        = 1'($urandom_range(0, 1));
    wb_addr    = 5'($urandom);
    wb_data    = $urandom;
    exit_i     = 1'($urandom_range(0, 1));
    arm_a      = 1'b1;
    arm_b      = 1'b1;
    trig_pc_en = 1'($urandom_range(0, 1));
    trig_pc    = $urandom;
    rd_ready   = 1'($urandom_range(0, 1));
    repeat (3) tick();
    chk("rst_rdv_a",  rdv_a, 1'b0);
    chk("rst_busy_a", busy_a, 1'b0);
    chk("rst_trg_a",  trg_a, 1'b0);
    chk("rst_ent_a",  ent_a, 4'd0);
    chk("rst_rdv_b",  rdv_b, 1'b0);
    chk("rst_busy_b", busy_b, 1'b0);
    valid = 0; exit_i = 0; arm_a = 0; arm_b = 0; trig_pc_en = 0; rd_ready = 0;
    trig_pc = '0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", busy_a, 1'b0);
    pulse_arm(1'b0);
    chk("arm_busy", busy_a, 1'b1);
    chk("arm_trg",  trg_a, 1'b0);

    // Pre-trigger wrap: pc 0x28 triggers, four more, window 0x1c..0x38
    trig_pc_en = 1'b1;
    trig_pc    = 32'h28;
    for (int k = 0; k <= 10; k++) retire(32'(4 * k));
    chk("wrap_trg",   trg_a, 1'b1);
    chk("wrap_ent",   ent_a, 4'd8);
    chk("wrap_rdv_post", rdv_a, 1'b0);
    for (int k = 11; k <= 14; k++) retire(32'(4 * k));
    chk("wrap_busy",  busy_a, 1'b1);
    chk("wrap_ent_d", ent_a, 4'd8);
    drain(1'b0, 32'h1c, 8, 1'b0);

    // Early trigger on 2nd retire, drained under backpressure
    trig_pc = 32'h104;
    pulse_arm(1'b0);
    retire(32'h100);
    chk("early_trg0", trg_a, 1'b0);
    retire(32'h104);
    chk("early_trg1", trg_a, 1'b1);
    chk("early_ent2", ent_a, 4'd2);
    for (int k = 0; k < 4; k++) retire(32'h108 + 32'(4 * k));
    chk("early_ent",  ent_a, 4'd6);
    chk("early_rdv",  rdv_a, 1'b1);
    drain(1'b0, 32'h100, 6, 1'b1);

    // exit trigger, POST_TRIG=0, sparse valid
    trig_pc_en = 1'b0;
    pulse_arm(1'b1);
    retire(32'h200);
    tick();
    retire(32'h204);
    tick();
    tick();
    chk("exit_ent_pre", ent_b, 4'd2);
    exit_i = 1'b1;
    retire(32'h208);
    exit_i = 1'b0;
    chk("exit_busy", busy_b, 1'b1);
    chk("exit_trg",  trg_b, 1'b1);
    chk("exit_ent",  ent_b, 4'd3);
    chk("exit_a_idle", busy_a, 1'b0);
    drain(1'b1, 32'h200, 3, 1'b0);

    // Abort mid-drain, then re-arm and capture fresh records
    trig_pc_en = 1'b1;
    trig_pc    = 32'h300;
    pulse_arm(1'b0);
    for (int k = 0; k < 5; k++) retire(32'h300 + 32'(4 * k));
    chk("abort_rdv", rdv_a, 1'b1);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("abort_ent4", ent_a, 4'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_rdv0",  rdv_a, 1'b0);
    chk("abort_rdd0",  rdd_a, '0);
    chk("abort_busy0", busy_a, 1'b0);
    chk("abort_trg0",  trg_a, 1'b0);
    chk("abort_ent0",  ent_a, 4'd0);
    #2 rst_n = 1'b1;
    tick();
    trig_pc = 32'h404;
    pulse_arm(1'b0);
    for (int k = 0; k < 6; k++) retire(32'h400 + 32'(4 * k));
    chk("rearm_ent", ent_a, 4'd6);
    drain(1'b0, 32'h400, 6, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
